seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver for the ALU board. It scans
//  one hex digit per refresh slot onto a shared segment bus and drives the common anodes.
//  It adds a per-frame input snapshot (tear-free), dead-time between digits (no ghosting),
//  per-digit blank and decimal point, and optional leading-zero blanking.
//  Sits between the ALU result/opcode registers and the board's anode/segment pins.
// PARAMETERS
//  N_DIGITS     4       digits scanned, 2..8
//  REFRESH_DIV  100000  clk cycles each digit is lit (SHOW), >=1
//  GUARD_CYC    16      clk cycles all anodes off before each digit (GUARD), >=0
//  LZB_EN       0       1 = blank leading zero digits; digit 0 is never blanked
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst_n      in   1            synchronous reset, active low
//  en         in   1            1 = scan; 0 = display dark
//  digits     in   4*N_DIGITS   hex nibbles; digit i = digits[4i+3:4i], digit 0 = rightmost
//  dp         in   N_DIGITS     decimal point request per digit, 1 = on
//  blank      in   N_DIGITS     force digit dark, 1 = blank
//  anode      out  N_DIGITS     active-low common anode select, at most one bit low
//  segs       out  7            active-low segments {g,f,e,d,c,b,a}
//  dp_n       out  1            active-low decimal point
//  frame_done out  1            one-cycle pulse at end of last digit's SHOW slot
// BEHAVIOUR
//  Clock and reset:
//  - One clock domain. Reset is synchronous, active low: rst_n sampled low at a rising clk edge resets.
//  - Reset values: anode all 1, segs 7'h7F, dp_n 1, frame_done 0, state OFF, idx 0,
//    slot counter 0, snapshot 0.
//  - All outputs are registered and change on the same edge as the state register.
//  States:
//  - OFF: anodes all 1, segs 7'h7F, dp_n 1. When en=1, go to GUARD with idx=0,
//    or to SHOW if GUARD_CYC=0. On this transition, latch digits, dp and blank into the snapshot.
//  - GUARD: outputs dark for exactly GUARD_CYC cycles, then SHOW.
//  - SHOW: anode[idx]=0, other anodes 1, for exactly REFRESH_DIV cycles.
//    - segs = hex decode of snapshot nibble idx:
//      0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//    - dp_n = ~snap_dp[idx].
//    - If snap_blank[idx]=1, or the LZB rule blanks the digit: segs=7'h7F and dp_n=1.
//      The anode still goes low so scan timing is unchanged.
//  - End of SHOW, idx<N_DIGITS-1: idx+1, go to GUARD (or SHOW if GUARD_CYC=0).
//  - End of SHOW, idx=N_DIGITS-1:
//    - frame_done=1 for that one cycle; idx wraps to 0.
//    - Re-latch the snapshot from the live inputs, then go to GUARD/SHOW.
//  Snapshot:
//  - Input changes mid-frame are not visible until the next frame.
//  Leading-zero blanking (LZB_EN=1):
//  - Digit i>0 is blanked when snapshot nibbles i..N_DIGITS-1 are all zero.
//  - Evaluated on the snapshot, combinationally, from idx.
//  Enable and reset mid-operation:
//  - en=0 in any state: next edge -> OFF, outputs dark, idx 0, counters 0, no frame_done.
//  - rst_n=0 mid-slot: next edge returns all registers to their reset values.
//    Scanning restarts at digit 0 after reset is released with en=1.
//  Timing and widths:
//  - Frame period = N_DIGITS*(GUARD_CYC+REFRESH_DIV) cycles.
//  - Slot counter width = $clog2(max(REFRESH_DIV,GUARD_CYC)+1); it counts 0..limit-1 and clears on each transition.
// TESTING
//  (N_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1, LZB_EN=0 unless stated)
//  1 Reset release, en=1, digits=16'h12AF -> anode sequence per 5 cycles: 1111,1110x4,
//    1111,1101x4,... ; segs 0E,08,24,79 on digits 0..3; frame_done pulses every 20 cycles.
//  2 Change digits to 16'h0000 in the middle of digit 2's SHOW slot -> rest of the frame still
//    shows old values; next frame shows 40 on all digits.
//  3 dp=4'b0100, blank=4'b0001 -> dp_n=0 only while anode=1011; digit 0 segs=7F,
//    and anode 1110 is still asserted for 4 cycles.
//  4 LZB_EN=1, digits=16'h0030 -> digits 3,2 segs=7F; digit1=30; digit0=40.
//    digits=16'h0000 -> only digit 0 lit, showing 40.
//  5 en=0 in the middle of digit 1's slot -> next edge anode=1111, segs=7F, no frame_done.
//    en=1 again -> restart at digit 0 after 1 GUARD cycle.
//  6 rst_n=0 for 1 cycle mid-SHOW -> next edge all outputs at reset values, idx=0.
//    GUARD_CYC=0 build -> no dark cycle between digits, and the period is 16 cycles.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner.
// Frame snapshot, guard dead-time, blanking, dp, optional LZB.
module seven_seg_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 16,
    parameter int LZB_EN      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    output logic [N_DIGITS-1:0]   anode,
    output logic [6:0]            segs,
    output logic                  dp_n,
    output logic                  frame_done
);

    localparam int MAXC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(N_DIGITS);

    localparam logic [CW-1:0] C_SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IW-1:0] C_IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_GUARD,
        S_SHOW
    } state_t;

    localparam state_t S_START = (GUARD_CYC > 0) ? S_GUARD : S_SHOW;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [4*N_DIGITS-1:0] r_snap_dig;
    logic [N_DIGITS-1:0]   r_snap_dp;
    logic [N_DIGITS-1:0]   r_snap_blank;
    logic [N_DIGITS-1:0]   r_anode;
    logic [6:0]            r_segs;
    logic                  r_dp_n;
    logic                  r_fd;

    state_t                w_state_nx;
    logic [IW-1:0]         w_idx_nx;
    logic [CW-1:0]         w_cnt_nx;
    logic                  w_load;
    logic [4*N_DIGITS-1:0] w_snap_dig_nx;
    logic [N_DIGITS-1:0]   w_snap_dp_nx;
    logic [N_DIGITS-1:0]   w_snap_blank_nx;
    logic [3:0]            w_nib;
    logic                  w_off;
    logic [N_DIGITS-1:0]   w_anode_nx;
    logic [6:0]            w_segs_nx;
    logic                  w_dp_n_nx;
    logic                  w_fd_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Digit i>0 goes dark when it and every digit to its left is zero.
    function automatic logic lz_blank(
        input logic [4*N_DIGITS-1:0] s,
        input logic [IW-1:0]         i
    );
        logic z;
        z = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= int'(i) && s[4*k +: 4] != 4'h0) begin
                z = 1'b0;
            end
        end
        return (LZB_EN != 0) && (i != '0) && z;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        if (!en) begin
            w_state_nx = S_OFF;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    w_state_nx = S_START;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_load     = 1'b1;
                end
                S_GUARD: begin
                    if (r_cnt == C_GUARD_LAST) begin
                        w_state_nx = S_SHOW;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (r_cnt == C_SHOW_LAST) begin
                        w_state_nx = S_START;
                        w_cnt_nx   = '0;
                        if (r_idx == C_IDX_LAST) begin
                            w_idx_nx = '0;
                            w_load   = 1'b1;
                        end else begin
                            w_idx_nx = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nx = S_OFF;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so they register with the state.
    always_comb begin
        w_snap_dig_nx   = w_load ? digits : r_snap_dig;
        w_snap_dp_nx    = w_load ? dp : r_snap_dp;
        w_snap_blank_nx = w_load ? blank : r_snap_blank;
        w_nib           = w_snap_dig_nx[4*w_idx_nx +: 4];
        w_off           = w_snap_blank_nx[w_idx_nx]
                        | lz_blank(w_snap_dig_nx, w_idx_nx);
        w_anode_nx      = '1;
        w_segs_nx       = 7'h7F;
        w_dp_n_nx       = 1'b1;
        w_fd_nx         = 1'b0;
        if (w_state_nx == S_SHOW) begin
            w_anode_nx = ~(N_DIGITS'(1) << w_idx_nx);
            if (!w_off) begin
                w_segs_nx = hex7(w_nib);
                w_dp_n_nx = ~w_snap_dp_nx[w_idx_nx];
            end
            w_fd_nx = (w_idx_nx == C_IDX_LAST) && (w_cnt_nx == C_SHOW_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_OFF;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_snap_dig   <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_anode      <= '1;
            r_segs       <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_fd         <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_cnt        <= w_cnt_nx;
            r_snap_dig   <= w_snap_dig_nx;
            r_snap_dp    <= w_snap_dp_nx;
            r_snap_blank <= w_snap_blank_nx;
            r_anode      <= w_anode_nx;
            r_segs       <= w_segs_nx;
            r_dp_n       <= w_dp_n_nx;
            r_fd         <= w_fd_nx;
        end
    end

    assign anode      = r_anode;
    assign segs       = r_segs;
    assign dp_n       = r_dp_n;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: base build,
// leading-zero-blanking build and zero-guard build.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;

    logic [3:0]  a_an, l_an, g_an;
    logic [6:0]  a_sg, l_sg, g_sg;
    logic        a_dp, l_dp, g_dp;
    logic        a_fd, l_fd, g_fd;

    int errors = 0;
    int checks = 0;

    int pos, slot, f;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic       e_dp, e_fd;

    logic [6:0] tbl1 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [6:0] tblg [4] = '{7'h40, 7'h30, 7'h40, 7'h40};

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(1), .LZB_EN(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
        .blank(blank), .anode(a_an), .segs(a_sg), .dp_n(a_dp),
        .frame_done(a_fd)
    );

    seven_seg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(1), .LZB_EN(1)
    ) u_lz (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
        .blank(blank), .anode(l_an), .segs(l_sg), .dp_n(l_dp),
        .frame_done(l_fd)
    );

    seven_seg_scan_driver #(
        .N_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(0), .LZB_EN(0)
    ) u_g0 (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp(dp),
        .blank(blank), .anode(g_an), .segs(g_sg), .dp_n(g_dp),
        .frame_done(g_fd)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        digits = 16'h12AF;
        dp     = 4'b0000;
        blank  = 4'b0000;
        step();
        step();
        chk("rst_anode", {4'h0, a_an}, 8'h0F);
        chk("rst_segs", {1'b0, a_sg}, 8'h7F);
        chk("rst_dpn", {7'h0, a_dp}, 8'h01);
        chk("rst_fd", {7'h0, a_fd}, 8'h00);

        // scan, snapshot on mid-frame change, dp/blank, then en drop
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 108; k++) begin
            step();
            pos  = (k - 1) % 20;
            slot = pos / 5;
            f    = (k - 1) / 20;
            lit  = (pos % 5) != 0;
            e_an = lit ? ~(4'b0001 << slot) : 4'hF;
            if (!lit)                    e_sg = 7'h7F;
            else if (f >= 4 && slot == 0) e_sg = 7'h7F;
            else if (f >= 3)             e_sg = 7'h40;
            else                         e_sg = tbl1[slot];
            e_dp = !(lit && f >= 4 && slot == 2);
            e_fd = (pos == 19);
            chk("scan_anode", {4'h0, a_an}, {4'h0, e_an});
            chk("scan_segs", {1'b0, a_sg}, {1'b0, e_sg});
            chk("scan_dpn", {7'h0, a_dp}, {7'h0, e_dp});
            chk("scan_fd", {7'h0, a_fd}, {7'h0, e_fd});
            if (k == 53) digits = 16'h0000;
            if (k == 80) begin
                dp    = 4'b0100;
                blank = 4'b0001;
            end
        end

        en = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            chk("off_anode", {4'h0, a_an}, 8'h0F);
            chk("off_segs", {1'b0, a_sg}, 8'h7F);
            chk("off_dpn", {7'h0, a_dp}, 8'h01);
            chk("off_fd", {7'h0, a_fd}, 8'h00);
        end
        en = 1'b1;
        step();
        chk("reen_guard", {4'h0, a_an}, 8'h0F);
        step();
        chk("reen_d0", {4'h0, a_an}, 8'h0E);
        chk("reen_d0_blank", {1'b0, a_sg}, 8'h7F);
        step();
        step();

        rst_n = 1'b0;
        step();
        chk("mrst_anode", {4'h0, a_an}, 8'h0F);
        chk("mrst_segs", {1'b0, a_sg}, 8'h7F);
        chk("mrst_dpn", {7'h0, a_dp}, 8'h01);
        chk("mrst_fd", {7'h0, a_fd}, 8'h00);
        rst_n = 1'b1;
        step();
        chk("mrst_guard", {4'h0, a_an}, 8'h0F);
        step();
        chk("mrst_d0", {4'h0, a_an}, 8'h0E);

        // LZB build and zero-guard build
        rst_n  = 1'b0;
        step();
        digits = 16'h0030;
        dp     = 4'b0000;
        blank  = 4'b0000;
        rst_n  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            pos  = (k - 1) % 20;
            slot = pos / 5;
            f    = (k - 1) / 20;
            lit  = (pos % 5) != 0;
            e_an = lit ? ~(4'b0001 << slot) : 4'hF;
            if (!lit)                   e_sg = 7'h7F;
            else if (slot == 0)         e_sg = 7'h40;
            else if (slot == 1 && f == 0) e_sg = 7'h30;
            else                        e_sg = 7'h7F;
            chk("lzb_anode", {4'h0, l_an}, {4'h0, e_an});
            chk("lzb_segs", {1'b0, l_sg}, {1'b0, e_sg});
            chk("lzb_fd", {7'h0, l_fd}, {7'h0, pos == 19});

            pos  = (k - 1) % 16;
            slot = pos / 4;
            f    = (k - 1) / 16;
            e_an = ~(4'b0001 << slot);
            e_sg = (f >= 2) ? 7'h40 : tblg[slot];
            chk("g0_anode", {4'h0, g_an}, {4'h0, e_an});
            chk("g0_segs", {1'b0, g_sg}, {1'b0, e_sg});
            chk("g0_fd", {7'h0, g_fd}, {7'h0, pos == 15});
            if (k == 20) digits = 16'h0000;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
